hpi_timed_bridge: RTL and testbench

HPI_TIMED_BRIDGE -- requirements
Module: hpi_timed_bridge

---
 rtl/hpi_pkg.sv | 29 ++
 rtl/hpi_timed_bridge_if.sv | 26 ++
 rtl/hpi_int_sync.sv | 44 ++++
 rtl/hpi_timed_bridge.sv | 175 +++++++++++++++++
 tb/tb_hpi_timed_bridge.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hpi_pkg.sv
// hpi_pkg: shared definitions for the HPI bridge.
//   hpi_state_t  - bridge FSM states
//   HPI_DATA / HPI_MAILBOX / HPI_ADDR / HPI_STATUS - HPI register selects
//   max4()       - elaboration helper used to size timing counters
package hpi_pkg;

   typedef enum logic [2:0] {
      RSTWAIT,
      IDLE,
      SETUP,
      STROBE,
      HOLD
   } hpi_state_t;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDR    = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/hpi_timed_bridge_if.sv
// hpi_timed_bridge_if: host-side request/response bundle of the HPI bridge.
//   iADDR/iDATA/iRD/iWR        host -> bridge request
//   oDATA/oRVALID/oWDONE/oBUSY bridge -> host response
// Modports: master (host side), slave (bridge side).
interface hpi_timed_bridge_if #(
   parameter int HOST_DW = 32
);
   logic [1:0]         iADDR;
   logic [HOST_DW-1:0] iDATA;
   logic               iRD;
   logic               iWR;
   logic [HOST_DW-1:0] oDATA;
   logic               oRVALID;
   logic               oWDONE;
   logic               oBUSY;

   modport master (
      output iADDR, iDATA, iRD, iWR,
      input  oDATA, oRVALID, oWDONE, oBUSY
   );

   modport slave (
      input  iADDR, iDATA, iRD, iWR,
      output oDATA, oRVALID, oWDONE, oBUSY
   );
endinterface

// File: rtl/hpi_int_sync.sv
// hpi_int_sync: two-flop synchroniser for the asynchronous HPI interrupt plus
// a sticky rising-edge flag.
//   clk, rst   clock, asynchronous active-high reset
//   async_in   raw HPI_INT pin
//   clr        clears the sticky flag (a coincident new edge wins)
//   level      synchronised interrupt level
//   edge_flag  sticky: a 0->1 transition of level has been seen
module hpi_int_sync
   import hpi_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   input  logic clr,
   output logic level,
   output logic edge_flag
);
   logic sync1_reg, sync2_reg, prev_reg, flag_reg;
   logic rise;

   // prev_reg lags level by one cycle, so rise is high during the first
   // cycle in which level reads 1.
   assign rise = sync2_reg & ~prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         flag_reg  <= 1'b0;
      end else begin
         sync1_reg <= async_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         if (rise)
            flag_reg <= 1'b1;
         else if (clr)
            flag_reg <= 1'b0;
      end
   end

   assign level     = sync2_reg;
   assign edge_flag = flag_reg;
endmodule

// File: rtl/hpi_timed_bridge.sv
// hpi_timed_bridge: host-to-HPI bridge with fixed setup/strobe/hold timing.
// A host access (32 or 16 bit) becomes HOST_DW/16 HPI cycles to the same
// register, low half first, with CS_N held low across all of them.
//   iCLK, iRST   clock, asynchronous active-high reset
//   host         hpi_timed_bridge_if.slave: request in, data/pulses/busy out
//   iINT_CLR     clear sticky interrupt flag
//   oINT         synchronised HPI_INT level
//   oINT_EDGE    sticky rising-edge flag of oINT
//   HPI_*        HPI chip pins (data bus is bidirectional)
// HOST_DW must be 16 or 32; all cycle parameters must be >= 1.
module hpi_timed_bridge #(
   parameter int HOST_DW    = 32,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int RST_CYC    = 16
) (
   input  logic                iCLK,
   input  logic                iRST,
   hpi_timed_bridge_if.slave   host,
   input  logic                iINT_CLR,
   output logic                oINT,
   output logic                oINT_EDGE,
   inout  wire  [15:0]         HPI_DATA,
   output logic [1:0]          HPI_ADDR,
   output logic                HPI_RD_N,
   output logic                HPI_WR_N,
   output logic                HPI_CS_N,
   output logic                HPI_RST_N,
   input  logic                HPI_INT
);
   import hpi_pkg::*;

   localparam int BEATS = HOST_DW / 16;
   localparam int CW    = $clog2(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC) + 1);

   hpi_state_t     state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic           beat_reg, beat_next;
   logic           is_wr_reg;
   logic [1:0]     addr_reg;
   logic [31:0]    wdata_reg;
   logic [31:0]    rbuf_reg;
   logic [HOST_DW-1:0] odata_reg;
   logic           rvalid_reg, wdone_reg;

   logic [31:0]    wide_in;
   logic           accept, phase_last, last_beat, strobe_end, finish;
   logic           active, data_oe;
   logic [15:0]    wr_half;

   // Host data is kept 32 bits wide internally; a 16-bit host uses the low half.
   generate
      if (HOST_DW == 32) begin : g_dw32
         assign wide_in = host.iDATA;
      end else begin : g_dw16
         assign wide_in = {16'h0000, host.iDATA};
      end
   endgenerate

   assign accept     = (state_reg == IDLE) && (host.iWR || host.iRD);
   assign last_beat  = (beat_reg == 1'(BEATS - 1));
   assign strobe_end = (state_reg == STROBE) && phase_last;
   assign finish     = (state_reg == HOLD) && phase_last && last_beat;

   // Next state and counter. The counter restarts at every phase change and
   // never runs past the phase limit, so it cannot wrap.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CW'(1);
      beat_next  = beat_reg;
      phase_last = 1'b0;
      case (state_reg)
         RSTWAIT: begin
            phase_last = (cnt_reg == CW'(RST_CYC - 1));
            if (phase_last) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         IDLE: begin
            cnt_next = '0;
            if (accept) begin
               state_next = SETUP;
               beat_next  = 1'b0;
            end
         end
         SETUP: begin
            phase_last = (cnt_reg == CW'(SETUP_CYC - 1));
            if (phase_last) begin
               state_next = STROBE;
               cnt_next   = '0;
            end
         end
         STROBE: begin
            phase_last = (cnt_reg == CW'(STROBE_CYC - 1));
            if (phase_last) begin
               state_next = HOLD;
               cnt_next   = '0;
            end
         end
         HOLD: begin
            phase_last = (cnt_reg == CW'(HOLD_CYC - 1));
            if (phase_last) begin
               cnt_next = '0;
               if (last_beat) begin
                  state_next = IDLE;
               end else begin
                  state_next = SETUP;
                  beat_next  = beat_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = RSTWAIT;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_reg  <= RSTWAIT;
         cnt_reg    <= '0;
         beat_reg   <= 1'b0;
         is_wr_reg  <= 1'b0;
         addr_reg   <= 2'd0;
         wdata_reg  <= '0;
         rbuf_reg   <= '0;
         odata_reg  <= '0;
         rvalid_reg <= 1'b0;
         wdone_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         beat_reg  <= beat_next;
         // Write wins over a simultaneous read.
         if (accept) begin
            is_wr_reg <= host.iWR;
            addr_reg  <= host.iADDR;
            wdata_reg <= wide_in;
         end
         if (strobe_end && !is_wr_reg)
            rbuf_reg[{beat_reg, 4'b0000} +: 16] <= HPI_DATA;
         if (finish && !is_wr_reg)
            odata_reg <= rbuf_reg[HOST_DW-1:0];
         rvalid_reg <= finish && !is_wr_reg;
         wdone_reg  <= finish && is_wr_reg;
      end
   end

   assign active    = (state_reg == SETUP) || (state_reg == STROBE) || (state_reg == HOLD);
   assign data_oe   = active && is_wr_reg;
   assign wr_half   = wdata_reg[{beat_reg, 4'b0000} +: 16];
   assign HPI_DATA  = data_oe ? wr_half : 16'hzzzz;
   assign HPI_ADDR  = addr_reg;
   assign HPI_CS_N  = !active;
   assign HPI_RD_N  = !((state_reg == STROBE) && !is_wr_reg);
   assign HPI_WR_N  = !((state_reg == STROBE) && is_wr_reg);
   assign HPI_RST_N = (state_reg != RSTWAIT);

   assign host.oDATA   = odata_reg;
   assign host.oRVALID = rvalid_reg;
   assign host.oWDONE  = wdone_reg;
   assign host.oBUSY   = (state_reg != IDLE);

   hpi_int_sync u_int_sync (
      .clk       (iCLK),
      .rst       (iRST),
      .async_in  (HPI_INT),
      .clr       (iINT_CLR),
      .level     (oINT),
      .edge_flag (oINT_EDGE)
   );
endmodule

// File: tb/tb_hpi_timed_bridge.sv
// tb_hpi_timed_bridge: directed self-checking bench for hpi_timed_bridge with
// default parameters and a simple HPI read-data model.
module tb_hpi_timed_bridge;
   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iINT_CLR = 1'b0;
   logic        oINT, oINT_EDGE;
   wire  [15:0] HPI_DATA;
   logic [1:0]  HPI_ADDR;
   logic        HPI_RD_N, HPI_WR_N, HPI_CS_N, HPI_RST_N;
   logic        HPI_INT = 1'b0;

   hpi_timed_bridge_if #(.HOST_DW(32)) bus ();

   hpi_timed_bridge dut (
      .iCLK      (iCLK),
      .iRST      (iRST),
      .host      (bus.slave),
      .iINT_CLR  (iINT_CLR),
      .oINT      (oINT),
      .oINT_EDGE (oINT_EDGE),
      .HPI_DATA  (HPI_DATA),
      .HPI_ADDR  (HPI_ADDR),
      .HPI_RD_N  (HPI_RD_N),
      .HPI_WR_N  (HPI_WR_N),
      .HPI_CS_N  (HPI_CS_N),
      .HPI_RST_N (HPI_RST_N),
      .HPI_INT   (HPI_INT)
   );

   always #5 iCLK = ~iCLK;

   // HPI chip model: returns 0x1234 on the first read strobe, 0xABCD after.
   int          rd_rises = 0;
   int          rd_base  = 0;
   logic [15:0] model_word;
   always @(posedge HPI_RD_N) rd_rises++;
   always_comb model_word = ((rd_rises - rd_base) == 0) ? 16'h1234 : 16'hABCD;
   assign HPI_DATA = !HPI_RD_N ? model_word : 16'hzzzz;

   // Event counters
   int wr_pulses = 0, rd_pulses = 0, wdone_cnt = 0, rvalid_cnt = 0;
   always @(negedge HPI_WR_N) wr_pulses++;
   always @(negedge HPI_RD_N) rd_pulses++;
   always @(posedge iCLK) if (bus.oWDONE) wdone_cnt++;
   always @(posedge iCLK) if (bus.oRVALID) rvalid_cnt++;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Observations of one access
   int          done_cyc, wr_low, rd_low, cs_gap, oe_seen;
   logic [15:0] half0, half1;
   logic [1:0]  addr_seen;
   logic        wdone_seen, rvalid_seen, busy_at_done;

   task automatic run_access(input logic wr, input logic rd, input logic [1:0] addr,
                             input logic [31:0] data, input logic poke_rd);
      int cyc;
      done_cyc = 0; wr_low = 0; rd_low = 0; cs_gap = 0; oe_seen = 0;
      half0 = '0; half1 = '0; addr_seen = '0;
      wdone_seen = 0; rvalid_seen = 0; busy_at_done = 1;
      @(negedge iCLK);
      bus.iWR = wr; bus.iRD = rd; bus.iADDR = addr; bus.iDATA = data;
      @(posedge iCLK); #1;
      bus.iWR = 0; bus.iRD = 0; bus.iADDR = ~addr; bus.iDATA = ~data;
      cyc = 1;
      while (cyc <= 40 && done_cyc == 0) begin
         if (poke_rd) bus.iRD = (cyc == 5);
         if (bus.oWDONE || bus.oRVALID) begin
            done_cyc = cyc;
            wdone_seen = bus.oWDONE;
            rvalid_seen = bus.oRVALID;
            busy_at_done = bus.oBUSY;
         end else if (HPI_CS_N) begin
            cs_gap++;
         end else begin
            if (dut.data_oe) oe_seen++;
            if (!HPI_WR_N) begin
               if (wr_low < 4) half0 = HPI_DATA; else half1 = HPI_DATA;
               wr_low++;
               addr_seen = HPI_ADDR;
            end
            if (!HPI_RD_N) begin
               rd_low++;
               addr_seen = HPI_ADDR;
            end
         end
         @(posedge iCLK); #1;
         cyc++;
      end
      bus.iRD = 0;
   endtask

   int b_wr, b_rd, b_wd, b_rv;

   initial begin
      bus.iWR = 0; bus.iRD = 0; bus.iADDR = 0; bus.iDATA = 0;

      // Reset state
      repeat (3) @(posedge iCLK);
      #1;
      check("rst_hpi_rst_n", HPI_RST_N, 0);
      check("rst_busy", bus.oBUSY, 1);
      check("rst_cs_n", HPI_CS_N, 1);
      check("rst_rd_n", HPI_RD_N, 1);
      check("rst_wr_n", HPI_WR_N, 1);
      check("rst_data_oe", dut.data_oe, 0);
      check("rst_odata", bus.oDATA, 0);
      check("rst_oint", oINT, 0);

      // Reset release: 16 cycles of HPI_RST_N low, then idle
      @(negedge iCLK);
      iRST = 0;
      for (int i = 0; i < 16; i++) begin
         check("rstwait_rst_n_low", HPI_RST_N, 0);
         check("rstwait_busy", bus.oBUSY, 1);
         @(posedge iCLK); #1;
      end
      check("rstrel_rst_n_high", HPI_RST_N, 1);
      check("rstrel_busy_low", bus.oBUSY, 0);

      // 32-bit write of 0xDEADBEEF to address 0
      b_wr = wr_pulses; b_rd = rd_pulses;
      run_access(1, 0, 2'd0, 32'hDEAD_BEEF, 0);
      check("wr_done_cycle", done_cyc, 17);
      check("wr_wdone", wdone_seen, 1);
      check("wr_no_rvalid", rvalid_seen, 0);
      check("wr_busy_at_done", busy_at_done, 0);
      check("wr_half0", half0, 16'hBEEF);
      check("wr_half1", half1, 16'hDEAD);
      check("wr_strobe_cycles", wr_low, 8);
      check("wr_strobe_pulses", wr_pulses - b_wr, 2);
      check("wr_no_rd_strobe", rd_pulses - b_rd, 0);
      check("wr_cs_gap", cs_gap, 0);
      check("wr_drive_cycles", oe_seen, 16);
      check("wr_addr", addr_seen, 2'd0);
      check("wr_wdone_one_cycle", bus.oWDONE, 0);

      // 32-bit read from address 2
      rd_base = rd_rises;
      b_wr = wr_pulses; b_rd = rd_pulses;
      run_access(0, 1, 2'd2, 32'h0, 0);
      check("rd_done_cycle", done_cyc, 17);
      check("rd_rvalid", rvalid_seen, 1);
      check("rd_no_wdone", wdone_seen, 0);
      check("rd_odata", bus.oDATA, 32'hABCD_1234);
      check("rd_strobe_cycles", rd_low, 8);
      check("rd_strobe_pulses", rd_pulses - b_rd, 2);
      check("rd_no_wr_strobe", wr_pulses - b_wr, 0);
      check("rd_bus_not_driven", oe_seen, 0);
      check("rd_cs_gap", cs_gap, 0);
      check("rd_addr", addr_seen, 2'd2);
      check("rd_rvalid_one_cycle", bus.oRVALID, 0);

      // Simultaneous read+write, then a read poked while busy
      b_wr = wr_pulses; b_rd = rd_pulses; b_wd = wdone_cnt; b_rv = rvalid_cnt;
      run_access(1, 1, 2'd1, 32'h0BAD_F00D, 1);
      repeat (5) @(posedge iCLK);
      #1;
      check("both_done_cycle", done_cyc, 17);
      check("both_wr_pulses", wr_pulses - b_wr, 2);
      check("both_rd_pulses", rd_pulses - b_rd, 0);
      check("both_wdone_count", wdone_cnt - b_wd, 1);
      check("both_rvalid_count", rvalid_cnt - b_rv, 0);
      check("both_half0", half0, 16'hF00D);
      check("both_half1", half1, 16'h0BAD);
      check("both_addr", addr_seen, 2'd1);
      check("odata_held", bus.oDATA, 32'hABCD_1234);
      check("both_idle", bus.oBUSY, 0);

      // Interrupt: clear coincides with the first cycle oINT is high
      @(negedge iCLK);
      HPI_INT = 1;
      @(posedge iCLK); #1;
      check("int_sync_stage1", oINT, 0);
      @(posedge iCLK); #1;
      check("int_level", oINT, 1);
      check("int_edge_not_yet", oINT_EDGE, 0);
      iINT_CLR = 1;
      @(posedge iCLK); #1;
      iINT_CLR = 0;
      check("int_edge_set_wins", oINT_EDGE, 1);
      @(posedge iCLK); #1;
      check("int_edge_sticky", oINT_EDGE, 1);
      iINT_CLR = 1;
      @(posedge iCLK); #1;
      iINT_CLR = 0;
      check("int_edge_cleared", oINT_EDGE, 0);
      check("int_level_kept", oINT, 1);

      // Reset during the second write strobe
      b_wr = wr_pulses; b_wd = wdone_cnt;
      @(negedge iCLK);
      bus.iWR = 1; bus.iADDR = 2'd3; bus.iDATA = 32'h1111_2222;
      @(posedge iCLK); #1;
      bus.iWR = 0;
      for (int c = 1; c < 12; c++) begin
         @(posedge iCLK); #1;
      end
      check("mid_in_strobe", HPI_WR_N, 0);
      check("mid_beat2_data", HPI_DATA, 16'h1111);
      #3;
      iRST = 1;
      #1;
      check("mid_rst_wr_n", HPI_WR_N, 1);
      check("mid_rst_rd_n", HPI_RD_N, 1);
      check("mid_rst_cs_n", HPI_CS_N, 1);
      check("mid_rst_data_oe", dut.data_oe, 0);
      check("mid_rst_hpi_rst_n", HPI_RST_N, 0);
      check("mid_rst_addr", HPI_ADDR, 2'd0);
      check("mid_rst_busy", bus.oBUSY, 1);
      check("mid_rst_odata", bus.oDATA, 0);
      check("mid_rst_oint", oINT, 0);
      check("mid_rst_oint_edge", oINT_EDGE, 0);
      check("mid_rst_wdone", bus.oWDONE, 0);
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      iRST = 0;
      repeat (25) @(posedge iCLK);
      #1;
      check("mid_no_wdone", wdone_cnt - b_wd, 0);
      check("mid_wr_pulses", wr_pulses - b_wr, 2);
      check("mid_recovered_idle", bus.oBUSY, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
